// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep sequencer and its dwell timer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sweep_pkg;

  localparam int VEC_W = 4;
  localparam int RES_W = 10;
  localparam logic [VEC_W-1:0] LAST_IDX = 4'd15;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/dwell_timer.sv
// Settle timer: counts cycles while enabled, flags the last of DWELL cycles.
// Latency: expired is combinational from the count; count updates each clk edge.
// Backpressure: none; clear dominates enable.
module dwell_timer #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] cnt_q, cnt_d;

  // Next count: hold, restart from zero, or advance one settle cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 8'd0;
    end else if (enable) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The count starts at zero in the first enabled cycle, so DWELL-1 marks the last one.
  assign expired = enable && (cnt_q == 8'(DWELL - 1));

endmodule

// File: rtl/sweep_sequencer.sv
// Drives all 16 {w,x,y,z} vectors in turn, captures r after DWELL settle cycles, presents one record per vector.
// Latency: first record DWELL cycles after start is accepted; DWELL+1 cycles per record with rec_ready held high.
// Backpressure: rec_ready=0 holds the record and the driven vector. Optional rec_parity output: SWEEP_PARITY_EN.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             w,
  output logic             x,
  output logic             y,
  output logic             z,
  input  logic [RES_W-1:0] r,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [VEC_W-1:0] rec_idx,
  output logic [RES_W-1:0] rec_result,
  output logic             busy,
`ifdef SWEEP_PARITY_EN
  output logic             rec_parity,
`endif
  output logic             done
);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic               rec_valid_q, rec_valid_d;
  logic [VEC_W-1:0]   rec_idx_q, rec_idx_d;
  logic [RES_W-1:0]   rec_result_q, rec_result_d;
  logic               done_q, done_d;
  logic               expired;
`ifdef SWEEP_PARITY_EN
  logic               rec_parity_q, rec_parity_d;
`endif

  // Timer runs only in DRIVE and is held at zero everywhere else, so each DRIVE entry starts fresh.
  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != DRIVE),
    .enable (state_q == DRIVE),
    .expired(expired)
  );

  // Next-state and record logic: start only in IDLE, capture at dwell expiry, advance on transfer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rec_valid_d  = rec_valid_q;
    rec_idx_d    = rec_idx_q;
    rec_result_d = rec_result_q;
    done_d       = 1'b0;
`ifdef SWEEP_PARITY_EN
    rec_parity_d = rec_parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (expired) begin
          rec_valid_d  = 1'b1;
          rec_idx_d    = idx_q;
          rec_result_d = r;
`ifdef SWEEP_PARITY_EN
          rec_parity_d = ^r;
`endif
          state_d      = PRESENT;
        end
      end
      PRESENT: begin
        // rec_valid is always high here, so rec_ready alone means a transfer.
        if (rec_ready) begin
          rec_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = DRIVE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and record registers; reset wins over start and over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      rec_valid_q  <= 1'b0;
      rec_idx_q    <= '0;
      rec_result_q <= '0;
      done_q       <= 1'b0;
`ifdef SWEEP_PARITY_EN
      rec_parity_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      rec_valid_q  <= rec_valid_d;
      rec_idx_q    <= rec_idx_d;
      rec_result_q <= rec_result_d;
      done_q       <= done_d;
`ifdef SWEEP_PARITY_EN
      rec_parity_q <= rec_parity_d;
`endif
    end
  end

  // idx is zero whenever IDLE, so the vector needs no extra gating.
  assign {w, x, y, z} = idx_q;
  assign rec_valid    = rec_valid_q;
  assign rec_idx      = rec_idx_q;
  assign rec_result   = rec_result_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
`ifdef SWEEP_PARITY_EN
  assign rec_parity   = rec_parity_q;
`endif

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: DWELL=4 instance for sweeps/backpressure/reset, DWELL=1 instance for short dwell.
// Latency: inputs driven 1 time unit after the rising edge, outputs compared there too.
// Backpressure: rec_ready driven per scenario. rec_parity checked when SWEEP_PARITY_EN is defined.
module tb_sweep_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, rec_ready;
  logic       w, x, y, z;
  logic [9:0] r;
  logic       rec_valid;
  logic [3:0] rec_idx;
  logic [9:0] rec_result;
  logic       busy, done;
  logic [3:0] vec;

  logic       start1, rdy1;
  logic       w1, x1, y1, z1;
  logic [9:0] r1;
  logic       vld1;
  logic [3:0] idx1;
  logic [9:0] res1;
  logic       busy1, done1;
  logic [3:0] vec1;
`ifdef SWEEP_PARITY_EN
  logic       par0, par1;
`endif

  // Stub gate block: r = 0x3F0 ^ idx.
  assign vec  = {w, x, y, z};
  assign r    = 10'h3F0 ^ {6'b0, vec};
  assign vec1 = {w1, x1, y1, z1};
  assign r1   = 10'h3F0 ^ {6'b0, vec1};

  always #5 clk = ~clk;

  sweep_sequencer #(.DWELL(4)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .w(w), .x(x), .y(y), .z(z), .r(r),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_result(rec_result),
    .busy(busy),
`ifdef SWEEP_PARITY_EN
    .rec_parity(par0),
`endif
    .done(done)
  );

  sweep_sequencer #(.DWELL(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .w(w1), .x(x1), .y(y1), .z(z1), .r(r1),
    .rec_valid(vld1), .rec_ready(rdy1),
    .rec_idx(idx1), .rec_result(res1),
    .busy(busy1),
`ifdef SWEEP_PARITY_EN
    .rec_parity(par1),
`endif
    .done(done1)
  );

  // Transfer / done monitor, sampled mid-cycle.
  logic [13:0] recs[$];
  int          done_seen = 0;
  always @(negedge clk) begin
    if (!rst && rec_valid && rec_ready) recs.push_back({rec_idx, rec_result});
    if (done) done_seen++;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       start;
    logic       rdy;
    logic       exp_vld;
    logic [3:0] exp_idx;
    logic [9:0] exp_res;
    logic [3:0] exp_vec;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t tbl[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rec(input logic [3:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (rec_valid && rec_idx == k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drive(input logic [3:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (busy && !rec_valid && vec == k) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_records(input string name, input int base, input int n);
    int bad;
    int got;
    logic [3:0] ei;
    bad = 0;
    got = recs.size() - base;
    check({name, " count"}, 32'(got), 32'(n));
    for (int i = 0; i < n && i < got; i++) begin
      ei = 4'(i % 16);
      if (recs[base + i] !== {ei, 10'h3F0 ^ {6'b0, ei}}) bad++;
    end
    check({name, " order"}, 32'(bad), 32'd0);
  endtask

  initial begin
    bit ok;
    int base;
    int dbase;

    // Basic sweep, cycle by cycle through the first two records (DWELL=4).
    //            start rdy  vld  idx   res      vec   busy done
    tbl[0] = '{1'b1, 1'b1, 1'b0, 4'd0, 10'h000, 4'd0, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 4'd0, 10'h3F0, 4'd0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd1, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 4'd0, 10'h000, 4'd1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 4'd1, 10'h3F1, 4'd1, 1'b1, 1'b0};

    rst = 1'b1; start = 1'b0; rec_ready = 1'b1; start1 = 1'b0; rdy1 = 1'b1;
    step(); step();
    check("reset vld",  32'(rec_valid),  32'd0);
    check("reset idx",  32'(rec_idx),    32'd0);
    check("reset res",  32'(rec_result), 32'd0);
    check("reset vec",  32'(vec),        32'd0);
    check("reset busy", 32'(busy),       32'd0);
    check("reset done", 32'(done),       32'd0);
`ifdef SWEEP_PARITY_EN
    check("reset parity", 32'(par0), 32'd0);
`endif
    rst = 1'b0;
    step();

    // Basic sweep.
    base = recs.size(); dbase = done_seen;
    for (int i = 0; i < 10; i++) begin
      start = tbl[i].start; rec_ready = tbl[i].rdy;
      step();
      check($sformatf("basic[%0d] vld", i),  32'(rec_valid), 32'(tbl[i].exp_vld));
      check($sformatf("basic[%0d] vec", i),  32'(vec),       32'(tbl[i].exp_vec));
      check($sformatf("basic[%0d] busy", i), 32'(busy),      32'(tbl[i].exp_busy));
      check($sformatf("basic[%0d] done", i), 32'(done),      32'(tbl[i].exp_done));
      if (tbl[i].exp_vld) begin
        check($sformatf("basic[%0d] idx", i), 32'(rec_idx),    32'(tbl[i].exp_idx));
        check($sformatf("basic[%0d] res", i), 32'(rec_result), 32'(tbl[i].exp_res));
      end
    end
    start = 1'b0;
    wait_done(200, ok);
    check("basic done seen", 32'(ok), 32'd1);
    check("basic done-cycle busy", 32'(busy), 32'd0);
    check("basic done-cycle vec",  32'(vec),  32'd0);
    step();
    check("basic done one cycle", 32'(done), 32'd0);
    check("basic busy after", 32'(busy), 32'd0);
    check_records("basic records", base, 16);
    check("basic done pulses", 32'(done_seen - dbase), 32'd1);

    // Backpressure at idx 5.
    base = recs.size();
    start = 1'b1; step(); start = 1'b0;
    wait_rec(4'd5, ok);
    check("bp reached idx5", 32'(ok), 32'd1);
    rec_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp[%0d] vld", i), 32'(rec_valid),  32'd1);
      check($sformatf("bp[%0d] idx", i), 32'(rec_idx),    32'd5);
      check($sformatf("bp[%0d] res", i), 32'(rec_result), 32'h3F5);
      check($sformatf("bp[%0d] vec", i), 32'(vec),        32'd5);
    end
    rec_ready = 1'b1;
    step();
    check("bp resume vec", 32'(vec), 32'd6);
    check("bp resume vld", 32'(rec_valid), 32'd0);
    wait_done(200, ok);
    check("bp done seen", 32'(ok), 32'd1);
    check_records("bp records", base, 16);

    // Start pulse while busy at idx 7.
    step();
    base = recs.size(); dbase = done_seen;
    start = 1'b1; step(); start = 1'b0;
    wait_rec(4'd7, ok);
    check("sb reached idx7", 32'(ok), 32'd1);
    start = 1'b1; step(); start = 1'b0;
    check("sb idx after pulse", 32'(vec), 32'd8);
    wait_done(200, ok);
    check("sb done seen", 32'(ok), 32'd1);
    step(); step(); step();
    check("sb busy after", 32'(busy), 32'd0);
    check_records("sb records", base, 16);
    check("sb done pulses", 32'(done_seen - dbase), 32'd1);

    // Reset mid-sweep while driving idx 9.
    base = recs.size();
    start = 1'b1; step(); start = 1'b0;
    wait_drive(4'd9, ok);
    check("rst reached idx9", 32'(ok), 32'd1);
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst vld",  32'(rec_valid),  32'd0);
    check("rst idx",  32'(rec_idx),    32'd0);
    check("rst res",  32'(rec_result), 32'd0);
    check("rst vec",  32'(vec),        32'd0);
    check("rst busy", 32'(busy),       32'd0);
    check("rst done", 32'(done),       32'd0);
    step(); step(); step();
    check("rst stays idle", 32'(busy), 32'd0);
    check("rst no new records", 32'(recs.size() - base), 32'd9);
    base = recs.size();
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("restart vld before", 32'(rec_valid), 32'd0);
    step();
    check("restart vld", 32'(rec_valid),  32'd1);
    check("restart idx", 32'(rec_idx),    32'd0);
    check("restart res", 32'(rec_result), 32'h3F0);
    wait_done(200, ok);
    check("restart done seen", 32'(ok), 32'd1);
    check_records("restart records", base, 16);

    // Back-to-back: start held through the done cycle.
    step();
    base = recs.size(); dbase = done_seen;
    start = 1'b1;
    wait_done(200, ok);
    check("b2b first done", 32'(ok), 32'd1);
    step();
    start = 1'b0;
    check("b2b busy again", 32'(busy), 32'd1);
    check("b2b vec restart", 32'(vec), 32'd0);
    wait_done(200, ok);
    check("b2b second done", 32'(ok), 32'd1);
    step();
    check_records("b2b records", base, 32);
    check("b2b done pulses", 32'(done_seen - dbase), 32'd2);

    // DWELL=1: record i valid right after edge 2i+1 following start acceptance.
    start1 = 1'b1; step(); start1 = 1'b0;
    check("d1 accept busy", 32'(busy1), 32'd1);
    check("d1 accept vld",  32'(vld1),  32'd0);
    for (int s = 1; s <= 11; s++) begin
      step();
      check($sformatf("d1[%0d] vld", s), 32'(vld1), 32'(s % 2));
      check($sformatf("d1[%0d] vec", s), 32'(vec1), 32'(s / 2));
      if (s % 2 == 1) begin
        check($sformatf("d1[%0d] idx", s), 32'(idx1), 32'((s - 1) / 2));
        check($sformatf("d1[%0d] res", s), 32'(res1), 32'(10'h3F0 + 10'((s - 1) / 2)));
      end
`ifdef SWEEP_PARITY_EN
      if (s == 3)  check("d1 parity idx1", 32'(par1), 32'd1);
      if (s == 11) check("d1 parity idx5", 32'(par1), 32'd0);
`endif
    end
    for (int i = 0; i < 100 && busy1; i++) step();
    check("d1 sweep ends", 32'(busy1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sweep_sequencer.md
SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter DWELL, default 4: the number of settle cycles each input vector is driven before capture; legal values are 1..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request a full 16-vector sweep.
REQ-005 SHALL have ports w, x, y, z, output, 1 bit each: the 4-bit vector driven to the gate block, with w as MSB and z as LSB.
REQ-006 SHALL have port r, input, 10 bits: result vector returned by the gate block, r[0]=f0 through r[9]=f9.
REQ-007 SHALL have port rec_valid, output, 1 bit: the captured record is available.
REQ-008 SHALL have port rec_ready, input, 1 bit: the consumer accepts the record.
REQ-009 SHALL have port rec_idx, output, 4 bits: vector index of the record.
REQ-010 SHALL have port rec_result, output, 10 bits: r sampled for that index.
REQ-011 SHALL have ports busy and done, output, 1 bit each: busy means a sweep is in progress; done is a one-cycle end-of-sweep pulse.

Function
REQ-012 SHALL implement the states IDLE, DRIVE and PRESENT.
REQ-013 In IDLE, start=1 at a clock edge SHALL set idx=0, clear the dwell counter, and enter DRIVE; busy=1 from that edge.
REQ-014 {w,x,y,z} SHALL equal idx in DRIVE and PRESENT, and SHALL stay stable throughout both.
REQ-015 DRIVE SHALL last exactly DWELL cycles; at the edge ending the last DRIVE cycle, r SHALL be captured into rec_result, idx into rec_idx, rec_valid SHALL go to 1, and the state SHALL become PRESENT.
REQ-016 Capture latency SHALL be DWELL cycles from the edge that accepts start to the first rec_valid=1.
REQ-017 In PRESENT, a transfer SHALL occur on an edge with rec_valid=1 and rec_ready=1; while rec_ready=0, rec_valid, rec_idx, rec_result and {w,x,y,z} SHALL all hold.
REQ-018 On a transfer with idx<15: rec_valid<=0, idx<=idx+1, dwell counter cleared, state DRIVE.
REQ-019 On a transfer with idx=15: rec_valid<=0, state IDLE, busy<=0, done<=1 for exactly one cycle, and {w,x,y,z} returns to 0000.
REQ-020 start SHALL be ignored in DRIVE and PRESENT; start is accepted in the IDLE cycle in which done=1.
REQ-021 idx SHALL NOT wrap within a sweep; exactly 16 records SHALL be produced per sweep, in index order 0..15.
REQ-022 rec_ready SHALL be ignored when rec_valid=0.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and set w=x=y=z=0, rec_valid=0, rec_idx=0, rec_result=0, busy=0, done=0, idx=0 and dwell counter=0.
REQ-024 Reset mid-sweep SHALL abandon the sweep with no further records; rst SHALL take priority over start and over any transfer on the same edge.

Configuration
REQ-025 With SWEEP_PARITY_EN defined, the block SHALL have an additional 1-bit output rec_parity equal to the XOR of all rec_result bits.
REQ-026 rec_parity SHALL be registered alongside rec_result and SHALL reset to 0.
REQ-027 Without SWEEP_PARITY_EN, the rec_parity port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-028 A shared package sweep_pkg SHALL hold the state enum (IDLE/DRIVE/PRESENT), VEC_W=4, RES_W=10, and LAST_IDX=15.
REQ-029 The dwell timer SHALL be a sub-module dwell_timer with inputs clk, rst, clear and enable, a parameter DWELL, and an output expired.
REQ-030 The rest of the block SHALL be flat in sweep_sequencer.

Verification
REQ-031 The bench SHALL use a stub gate model with r = 10'h3F0 ^ {6'b0,idx}, and SHALL cover these scenarios:
REQ-032 Basic sweep (DWELL=4, rec_ready tied 1, start pulse): records idx 0..15 with rec_result 0x3F0..0x3FF; first rec_valid arrives 4 cycles after start is accepted; done pulses once; busy then drops.
REQ-033 Backpressure: rec_ready=0 for 10 cycles at idx 5 -> rec_valid stays 1, rec_idx=5, rec_result=0x3F5 and {w,x,y,z}=0101 all hold; the sweep then resumes at idx 6.
REQ-034 Start while busy: a start pulse at idx 7 -> ignored; still exactly 16 records and one done pulse.
REQ-035 Reset mid-sweep: rst at idx 9 in DRIVE -> next cycle all outputs 0 and state IDLE; a new start restarts at idx 0.
REQ-036 Back-to-back: start held high through the done cycle -> a second sweep begins immediately, and 32 records are seen in total.
REQ-037 With SWEEP_PARITY_EN and DWELL=1: idx 5 -> rec_parity=0; idx 1 -> rec_result 0x3F1 with rec_parity=1; each record arrives 1 cycle after its DRIVE entry.
